// File: rtl/spi_4094_chain_driver.sv
// Serial driver for a daisy-chain of 4094 shift registers.
// Shifts a parallel word out MSB-first and captures the chain's QS' output as
// readback. It then pulses the strobe. Chain outputs stay disabled until the
// first complete load.
module spi_4094_chain_driver #(
   parameter int unsigned N_BYTES       = 3,
   parameter int unsigned CLK_DIV       = 4,
   parameter int unsigned STROBE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [8*N_BYTES-1:0]   data_in,
   input  logic                   oe_en,
   output logic                   busy,
   output logic                   done,
   output logic [8*N_BYTES-1:0]   readback,
   output logic                   sr_clk,
   output logic                   sr_data,
   output logic                   sr_strobe,
   input  logic                   sr_miso,
   output logic                   sr_oe
);

   localparam int unsigned W    = 8 * N_BYTES;
   localparam int unsigned CMAX = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned BW   = $clog2(W + 1);

   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      STROBE,
      DONE
   } state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  shreg, shreg_nxt;
   logic [W-1:0]  cap, cap_nxt;
   logic [CW-1:0] cyc_cnt, cyc_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt;
   logic          loaded;
   logic          busy_nxt, done_nxt, sr_clk_nxt, sr_data_nxt, sr_strobe_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state, datapath next values and next output values.
   // Outputs are registered from the next state, so every output is a flop.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cap_nxt   = cap;
      cyc_nxt   = cyc_cnt + 1'b1;
      bit_nxt   = bit_cnt;

      case (state)
         IDLE: begin
            cyc_nxt = '0;
            bit_nxt = '0;
            if (start) begin
               shreg_nxt = data_in;
               state_nxt = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (cyc_cnt == DIV_LAST) begin
               cyc_nxt   = '0;
               // Capture QS' as sr_clk rises (value set up on the previous fall)
               cap_nxt   = {cap[W-2:0], sr_miso};
               state_nxt = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (cyc_cnt == DIV_LAST) begin
               cyc_nxt   = '0;
               shreg_nxt = {shreg[W-2:0], 1'b0};
               bit_nxt   = bit_cnt + 1'b1;
               state_nxt = (bit_cnt == BIT_LAST) ? STROBE : SHIFT_LO;
            end
         end
         STROBE: begin
            if (cyc_cnt == STB_LAST) begin
               cyc_nxt   = '0;
               state_nxt = DONE;
            end
         end
         DONE: begin
            cyc_nxt   = '0;
            bit_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            cyc_nxt   = '0;
            bit_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt      = (state_nxt != IDLE);
      done_nxt      = (state_nxt == DONE);
      sr_clk_nxt    = (state_nxt == SHIFT_HI);
      sr_strobe_nxt = (state_nxt == STROBE);
      sr_data_nxt   = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) ? shreg_nxt[W-1] : 1'b0;
   end

   // Datapath, counters, readback, loaded flag and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg     <= '0;
         cap       <= '0;
         cyc_cnt   <= '0;
         bit_cnt   <= '0;
         readback  <= '0;
         loaded    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sr_clk    <= 1'b0;
         sr_data   <= 1'b0;
         sr_strobe <= 1'b0;
         sr_oe     <= 1'b0;
      end else begin
         shreg     <= shreg_nxt;
         cap       <= cap_nxt;
         cyc_cnt   <= cyc_nxt;
         bit_cnt   <= bit_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         sr_clk    <= sr_clk_nxt;
         sr_data   <= sr_data_nxt;
         sr_strobe <= sr_strobe_nxt;
         sr_oe     <= oe_en & loaded;
         if (state_nxt == DONE) begin
            readback <= cap_nxt;
            loaded   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_4094_chain_driver.sv
// Testbench for spi_4094_chain_driver: two instances (2-byte and minimum 1-byte
// chains), each driving a behavioural 4094 chain with output latch.
module tb_spi_4094_chain_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Instance A: N_BYTES=2, CLK_DIV=2, STROBE_CYCLES=2
   logic        start_a, oe_en_a, busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a, sr_miso_a, sr_oe_a;
   logic [15:0] data_a, readback_a;

   // Instance B: N_BYTES=1, CLK_DIV=1, STROBE_CYCLES=1
   logic        start_b, oe_en_b, busy_b, done_b, sr_clk_b, sr_data_b, sr_strobe_b, sr_miso_b, sr_oe_b;
   logic [7:0]  data_b, readback_b;

   spi_4094_chain_driver #(.N_BYTES(2), .CLK_DIV(2), .STROBE_CYCLES(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a), .oe_en(oe_en_a),
      .busy(busy_a), .done(done_a), .readback(readback_a), .sr_clk(sr_clk_a),
      .sr_data(sr_data_a), .sr_strobe(sr_strobe_a), .sr_miso(sr_miso_a), .sr_oe(sr_oe_a)
   );

   spi_4094_chain_driver #(.N_BYTES(1), .CLK_DIV(1), .STROBE_CYCLES(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b), .oe_en(oe_en_b),
      .busy(busy_b), .done(done_b), .readback(readback_b), .sr_clk(sr_clk_b),
      .sr_data(sr_data_b), .sr_strobe(sr_strobe_b), .sr_miso(sr_miso_b), .sr_oe(sr_oe_b)
   );

   // 4094 chain models: shift on CP rise, QS' updated on CP fall, latch on STR rise
   logic [15:0] chain_a = 16'hC3E1;
   logic        qs_a    = 1'b1;
   logic [15:0] latch_a = 16'h0000;
   always @(posedge sr_clk_a)    chain_a <= {chain_a[14:0], sr_data_a};
   always @(negedge sr_clk_a)    qs_a    <= chain_a[15];
   always @(posedge sr_strobe_a) latch_a <= chain_a;
   assign sr_miso_a = qs_a;

   logic [7:0] chain_b = 8'h5A;
   logic       qs_b    = 1'b0;
   logic [7:0] latch_b = 8'h00;
   always @(posedge sr_clk_b)    chain_b <= {chain_b[6:0], sr_data_b};
   always @(negedge sr_clk_b)    qs_b    <= chain_b[7];
   always @(posedge sr_strobe_b) latch_b <= chain_b;
   assign sr_miso_b = qs_b;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] data;
      logic        hammer;
      logic [15:0] exp_rb;
      logic [15:0] exp_latch;
      logic        exp_oe_done;
      logic        exp_oe_after;
   } vec_t;

   vec_t vecs[6];

   // One transfer on instance A; called at a negedge. With hammer set, start is
   // held high and data_in scrambled on every cycle while busy (DONE included).
   task automatic run_a(input int idx, input vec_t v);
      int          busy_n, done_n, strb_n, rises, cyc;
      logic [15:0] bits;
      logic        prev_clk, seen_busy, fin, after_done, oe_d, oe_a;
      string       tag;
      busy_n = 0; done_n = 0; strb_n = 0; rises = 0; cyc = 0; bits = '0;
      prev_clk = 1'b0; seen_busy = 1'b0; fin = 1'b0; after_done = 1'b0;
      oe_d = 1'b0; oe_a = 1'b0;
      tag = $sformatf("v%0d", idx);
      data_a  = v.data;
      start_a = 1'b1;
      while (!fin && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (after_done) begin
            oe_a = sr_oe_a;
            after_done = 1'b0;
         end
         if (busy_a) begin
            busy_n++;
            seen_busy = 1'b1;
         end else if (seen_busy) begin
            fin = 1'b1;
         end
         if (done_a) begin
            done_n++;
            oe_d = sr_oe_a;
            after_done = 1'b1;
         end
         if (sr_strobe_a) strb_n++;
         if (sr_clk_a && !prev_clk) begin
            bits = {bits[14:0], sr_data_a};
            rises++;
         end
         prev_clk = sr_clk_a;
         if (v.hammer && busy_a) begin
            start_a = 1'b1;
            data_a  = 16'($urandom);
         end else begin
            start_a = 1'b0;
         end
      end
      start_a = 1'b0;
      chk({tag, "_finished"}, 32'(fin), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd67);
      chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
      chk({tag, "_strobe_cycles"}, 32'(strb_n), 32'd2);
      chk({tag, "_clk_rises"}, 32'(rises), 32'd16);
      chk({tag, "_sr_data_bits"}, 32'(bits), 32'(v.data));
      chk({tag, "_readback"}, 32'(readback_a), 32'(v.exp_rb));
      chk({tag, "_model_latch"}, 32'(latch_a), 32'(v.exp_latch));
      chk({tag, "_oe_in_done"}, 32'(oe_d), 32'(v.exp_oe_done));
      chk({tag, "_oe_after_done"}, 32'(oe_a), 32'(v.exp_oe_after));
   endtask

   initial begin
      int          rises, cyc, busy_n, done_n, strb_n, clk_err, k;
      logic        prev;
      logic [7:0]  bits8;

      vecs[0] = '{16'hA55A, 1'b0, 16'hC3E1, 16'hA55A, 1'b0, 1'b1};
      vecs[1] = '{16'h1234, 1'b0, 16'hA55A, 16'h1234, 1'b1, 1'b1};
      vecs[2] = '{16'hBEEF, 1'b0, 16'h1234, 16'hBEEF, 1'b1, 1'b1};
      vecs[3] = '{16'h0000, 1'b1, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1};
      // after the aborted 0x0000 load (6 bits shifted into 0xFFFF): chain = 0xFFC0
      vecs[5] = '{16'h6C39, 1'b0, 16'hFFC0, 16'h6C39, 1'b0, 1'b1};

      rst_n = 1'b0; start_a = 1'b1; data_a = 16'h5555; oe_en_a = 1'b1;
      start_b = 1'b0; data_b = 8'h00; oe_en_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_outputs", {27'd0, done_a, sr_clk_a, sr_data_a, sr_strobe_a, sr_oe_a}, 32'd0);
      chk("rst_readback", 32'(readback_a), 32'd0);
      start_a = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("oe_before_load", 32'(sr_oe_a), 32'd0);
      chk("idle_not_busy", 32'(busy_a), 32'd0);

      for (int i = 0; i < 5; i++) run_a(i, vecs[i]);

      // oe_en drop and restore, one-cycle latency each way
      oe_en_a = 1'b0;
      @(negedge clk);
      chk("oe_drop", 32'(sr_oe_a), 32'd0);
      oe_en_a = 1'b1;
      @(negedge clk);
      chk("oe_restore", 32'(sr_oe_a), 32'd1);

      // Abort during SHIFT_HI of bit 5 (6th sr_clk rise)
      data_a = 16'h0000; start_a = 1'b1;
      rises = 0; cyc = 0; prev = 1'b0;
      while (rises < 6 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         start_a = 1'b0;
         if (sr_clk_a && !prev) rises++;
         prev = sr_clk_a;
      end
      chk("abort_reached_bit5", 32'(rises), 32'd6);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy_a), 32'd0);
      chk("abort_outputs", {27'd0, done_a, sr_clk_a, sr_data_a, sr_strobe_a, sr_oe_a}, 32'd0);
      chk("abort_readback", 32'(readback_a), 32'd0);
      rst_n = 1'b1;
      done_n = 0; strb_n = 0; busy_n = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_a) done_n++;
         if (sr_strobe_a) strb_n++;
         if (busy_a || sr_oe_a) busy_n++;
      end
      chk("abort_no_done", 32'(done_n), 32'd0);
      chk("abort_no_strobe", 32'(strb_n), 32'd0);
      chk("abort_idle_oe_off", 32'(busy_n), 32'd0);
      chk("abort_latch_kept", 32'(latch_a), 32'hFFFF);

      run_a(5, vecs[5]);

      // Minimum-parameter instance: 0x81, busy 18, sr_clk toggling every cycle
      data_b = 8'h81; start_b = 1'b1;
      busy_n = 0; done_n = 0; strb_n = 0; rises = 0; clk_err = 0; k = 0;
      cyc = 0; prev = 1'b0; bits8 = '0;
      while (cyc < 200 && !(busy_n > 0 && !busy_b)) begin
         @(negedge clk);
         cyc++;
         start_b = 1'b0;
         if (busy_b) begin
            if (k < 16 && sr_clk_b !== k[0]) clk_err++;
            k++;
            busy_n++;
         end
         if (done_b) done_n++;
         if (sr_strobe_b) strb_n++;
         if (sr_clk_b && !prev) begin
            bits8 = {bits8[6:0], sr_data_b};
            rises++;
         end
         prev = sr_clk_b;
      end
      chk("b_busy_cycles", 32'(busy_n), 32'd18);
      chk("b_clk_rises", 32'(rises), 32'd8);
      chk("b_clk_toggle_errs", 32'(clk_err), 32'd0);
      chk("b_sr_data_bits", 32'(bits8), 32'h81);
      chk("b_strobe_cycles", 32'(strb_n), 32'd1);
      chk("b_done_pulses", 32'(done_n), 32'd1);
      chk("b_readback", 32'(readback_b), 32'h5A);
      chk("b_model_latch", 32'(latch_b), 32'h81);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
